// File: rtl/spi_txn_pkg.sv
// Shared types and constants for the two-requester MCP23S17-style SPI frame arbiter.
package spi_txn_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO, ST_GAP} state_t;

  localparam int         FRAME_BITS      = 24;
  localparam logic [6:0] MCP23S17_OPCODE = 7'h20;
  localparam logic       RW_WRITE        = 1'b0;
  localparam logic       RW_READ         = 1'b1;

  // Reads send a zero data byte; the slave drives MISO during that byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] op, input logic we,
                                                        input logic [7:0] addr, input logic [7:0] wdata);
    return {op, we ? RW_WRITE : RW_READ, addr, we ? wdata : 8'h00};
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter; tick is high in the last cycle of each loaded interval.
module spi_clk_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/spi_txn_arb.sv
// Round-robin arbiter and mode-0 SPI master issuing 3-byte opcode/address/data frames.
module spi_txn_arb
  import spi_txn_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         CS_GAP     = 2,
  parameter logic [6:0] DEV_OPCODE = MCP23S17_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [7:0]  rdata_o,
  output logic        sclk_o,
  output logic        csn_o,
  output logic        mosi_o,
  input  logic        miso_i
);
  localparam int DW = 16;

  state_t                  state, nxt;
  logic                    rr_ptr, grant_sel, owner, we_q, hi_entry;
  logic [FRAME_BITS-1:0]   frame_new;
  logic [FRAME_BITS-2:0]   sr;
  logic [4:0]              bit_idx;
  logic [7:0]              rx;
  logic                    div_load, tick;
  logic [DW-1:0]           div_val;

  assign grant_sel = (&req_i) ? rr_ptr : req_i[1];
  assign frame_new = build_frame(DEV_OPCODE, we_i[grant_sel],
                                 addr_i[{grant_sel, 3'b000} +: 8],
                                 wdata_i[{grant_sel, 3'b000} +: 8]);

  spi_clk_div #(.W(DW)) u_div (
    .clk(clk), .rst(rst), .load(div_load), .load_val(div_val), .tick(tick)
  );

  always_comb begin
    nxt      = state;
    gnt_o    = '0;
    div_load = 1'b0;
    div_val  = DW'(CLK_DIV - 1);
    case (state)
      ST_IDLE: if (!rst && |req_i) begin
        gnt_o[grant_sel] = 1'b1;
        nxt              = ST_SETUP;
        div_load         = 1'b1;
      end
      ST_SETUP:    if (tick) begin nxt = ST_SHIFT_HI; div_load = 1'b1; end
      ST_SHIFT_HI: if (tick) begin nxt = ST_SHIFT_LO; div_load = 1'b1; end
      ST_SHIFT_LO: if (tick) begin
        div_load = 1'b1;
        if (bit_idx == 5'd0) begin
          nxt     = ST_GAP;
          div_val = DW'(CS_GAP - 1);
        end else begin
          nxt = ST_SHIFT_HI;
        end
      end
      ST_GAP:  if (tick) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      csn_o    <= 1'b1;
      sclk_o   <= 1'b0;
      mosi_o   <= 1'b0;
      done_o   <= '0;
      rdata_o  <= '0;
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      hi_entry <= 1'b0;
      sr       <= '0;
      rx       <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= nxt;
      done_o   <= '0;
      hi_entry <= 1'b0;
      // MISO is captured in the first cycle of SCLK high, during the data byte only.
      if (state == ST_SHIFT_HI && hi_entry && bit_idx < 5'd8) rx <= {rx[6:0], miso_i};
      case (state)
        ST_IDLE: if (|gnt_o) begin
          owner   <= grant_sel;
          rr_ptr  <= ~grant_sel;
          we_q    <= we_i[grant_sel];
          sr      <= frame_new[FRAME_BITS-2:0];
          mosi_o  <= frame_new[FRAME_BITS-1];
          csn_o   <= 1'b0;
          bit_idx <= 5'(FRAME_BITS - 1);
        end
        ST_SETUP: if (tick) begin
          sclk_o   <= 1'b1;
          hi_entry <= 1'b1;
        end
        ST_SHIFT_HI: if (tick) begin
          sclk_o <= 1'b0;
          mosi_o <= sr[FRAME_BITS-2];
          sr     <= {sr[FRAME_BITS-3:0], 1'b0};
        end
        ST_SHIFT_LO: if (tick) begin
          if (bit_idx == 5'd0) begin
            csn_o         <= 1'b1;
            mosi_o        <= 1'b0;
            done_o[owner] <= 1'b1;
            if (!we_q) rdata_o <= rx;
          end else begin
            sclk_o   <= 1'b1;
            hi_entry <= 1'b1;
            bit_idx  <= bit_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
